// File: rtl/multi_data_sync_pkg.sv
// multi_data_sync_pkg
// Shared constants for the multi-channel data synchronizer:
//   - default parameter values (bus width, channel count, sync depth)
//   - event mode encoding (level vs toggle enable)
//   - ch_width(): width of a channel index, never less than 1 bit
package multi_data_sync_pkg;

  localparam int DEF_BUS_WIDTH  = 8;
  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_NUM_STAGES = 2;

  localparam int MODE_LEVEL  = 0;  // rising edge of the enable is an event
  localparam int MODE_TOGGLE = 1;  // either edge of the enable is an event

  function automatic int ch_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync_pulse_gen.sv
// sync_pulse_gen
// One channel's enable synchronizer: NUM_STAGES flops into the CLK domain,
// followed by one edge-detect flop. pulse is a single-cycle event, combinational
// off the last sync stage and the edge flop.
// Ports:
//   CLK, RST  - destination clock, async active-high reset
//   async_in  - enable from the source domain
//   pulse     - event (rising edge in level mode, any edge in toggle mode)
module sync_pulse_gen
  import multi_data_sync_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int TOGGLE_MODE = MODE_LEVEL
) (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic pulse
);

  logic [NUM_STAGES-1:0] sync_q;
  logic                  prev_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[NUM_STAGES-2:0], async_in};
      prev_q <= sync_q[NUM_STAGES-1];
    end
  end

  // Both flops reset to 0, so an enable already high at reset release
  // yields exactly one event in either mode.
  assign pulse = (TOGGLE_MODE == MODE_TOGGLE) ? (sync_q[NUM_STAGES-1] ^ prev_q)
                                              : (sync_q[NUM_STAGES-1] & ~prev_q);

endmodule

// File: rtl/multi_data_sync.sv
// multi_data_sync
// Multi-channel enable-qualified bus synchronizer. Each channel's enable is
// synchronized and edge-detected; an event captures that channel's data into
// a hold register and marks it pending. A round-robin arbiter moves pending
// words into a single valid/ready output register, one word per cycle.
// Ports:
//   CLK, RST     - destination clock, async active-high reset
//   Unsync_Bus   - NUM_CH x BUS_WIDTH source data, channel c at [c*BUS_WIDTH +: BUS_WIDTH]
//   Bus_Enable   - per-channel enable from the source domain
//   Sync_Bus     - output data word
//   Sync_Chan    - channel index of Sync_Bus
//   Sync_Valid   - output word valid
//   Sync_Ready   - consumer accepts the word
// Optional (macro DATA_SYNC_OVERRUN_EN):
//   Overrun_Clr  - clears the overrun flags (a same-cycle set wins)
//   Overrun      - per-channel sticky flag: a pending word was overwritten
module multi_data_sync
  import multi_data_sync_pkg::*;
#(
  parameter  int BUS_WIDTH   = DEF_BUS_WIDTH,
  parameter  int NUM_CH      = DEF_NUM_CH,
  parameter  int NUM_STAGES  = DEF_NUM_STAGES,
  parameter  int TOGGLE_MODE = MODE_LEVEL,
  localparam int CH_W        = ch_width(NUM_CH)
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [NUM_CH*BUS_WIDTH-1:0] Unsync_Bus,
  input  logic [NUM_CH-1:0]           Bus_Enable,
  output logic [BUS_WIDTH-1:0]        Sync_Bus,
  output logic [CH_W-1:0]             Sync_Chan,
  output logic                        Sync_Valid,
  input  logic                        Sync_Ready
`ifdef DATA_SYNC_OVERRUN_EN
  ,
  input  logic                        Overrun_Clr,
  output logic [NUM_CH-1:0]           Overrun
`endif
);

  logic [NUM_CH-1:0]                evt;
  logic [NUM_CH-1:0][BUS_WIDTH-1:0] hold_q;
  logic [NUM_CH-1:0]                pending_q;
  logic [CH_W-1:0]                  ptr_q;
  logic [CH_W-1:0]                  win;
  logic [CH_W-1:0]                  ptr_nxt;
  logic [NUM_CH-1:0]                grant_vec;
  logic                             any_pend;
  logic                             load;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    sync_pulse_gen #(
      .NUM_STAGES  (NUM_STAGES),
      .TOGGLE_MODE (TOGGLE_MODE)
    ) u_sync (
      .CLK      (CLK),
      .RST      (RST),
      .async_in (Bus_Enable[c]),
      .pulse    (evt[c])
    );
  end

  assign load     = !Sync_Valid || Sync_Ready;
  assign any_pend = |pending_q;

  // Scan offsets from the far end back toward the pointer so the last hit,
  // i.e. the pending channel closest to the pointer, is the winner.
  always_comb begin
    win = '0;
    for (int i = NUM_CH-1; i >= 0; i--) begin
      if (pending_q[(int'(ptr_q) + i) % NUM_CH])
        win = CH_W'((int'(ptr_q) + i) % NUM_CH);
    end
  end

  assign ptr_nxt = (int'(win) == NUM_CH-1) ? '0 : win + CH_W'(1);

  always_comb begin
    grant_vec = '0;
    if (load && any_pend) grant_vec[win] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hold_q     <= '0;
      pending_q  <= '0;
      ptr_q      <= '0;
      Sync_Valid <= 1'b0;
      Sync_Bus   <= '0;
      Sync_Chan  <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++)
        if (evt[c]) hold_q[c] <= Unsync_Bus[c*BUS_WIDTH +: BUS_WIDTH];
      // A new event keeps the channel pending even if its old word is
      // granted this cycle; the output takes the old hold value.
      pending_q <= evt | (pending_q & ~grant_vec);
      if (load) begin
        Sync_Valid <= any_pend;
        if (any_pend) begin
          Sync_Bus  <= hold_q[win];
          Sync_Chan <= win;
          ptr_q     <= ptr_nxt;
        end
      end
    end
  end

`ifdef DATA_SYNC_OVERRUN_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) Overrun <= '0;
    else     Overrun <= (Overrun & ~{NUM_CH{Overrun_Clr}}) | (evt & pending_q & ~grant_vec);
  end
`endif

endmodule

// File: tb/tb_multi_data_sync.sv
// Bench for multi_data_sync: a level-mode and a toggle-mode instance share the
// same stimulus. A reference model (enable history array + pending/hold/arbiter
// arrays) predicts both outputs; directed tasks use literal expectations.
module tb_multi_data_sync;

  localparam int NS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ubus;
  logic [1:0]  en;
  logic        rdy;
  logic        oclr;
  logic [7:0]  bus_o  [2];
  logic [0:0]  chan_o [2];
  logic        vld_o  [2];
  logic [1:0]  ovr_o  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_data_sync #(.BUS_WIDTH(8), .NUM_CH(2), .NUM_STAGES(NS), .TOGGLE_MODE(0)) dut_lvl (
    .CLK(clk), .RST(rst), .Unsync_Bus(ubus), .Bus_Enable(en),
    .Sync_Bus(bus_o[0]), .Sync_Chan(chan_o[0]), .Sync_Valid(vld_o[0]), .Sync_Ready(rdy)
`ifdef DATA_SYNC_OVERRUN_EN
    , .Overrun_Clr(oclr), .Overrun(ovr_o[0])
`endif
  );

  multi_data_sync #(.BUS_WIDTH(8), .NUM_CH(2), .NUM_STAGES(NS), .TOGGLE_MODE(1)) dut_tgl (
    .CLK(clk), .RST(rst), .Unsync_Bus(ubus), .Bus_Enable(en),
    .Sync_Bus(bus_o[1]), .Sync_Chan(chan_o[1]), .Sync_Valid(vld_o[1]), .Sync_Ready(rdy)
`ifdef DATA_SYNC_OVERRUN_EN
    , .Overrun_Clr(oclr), .Overrun(ovr_o[1])
`endif
  );

  // ---------------- reference model (index m: 0 = level, 1 = toggle) -------
  bit [1:0] hist[$];          // enable vector sampled at each edge since reset
  bit [7:0] m_hold [2][2];
  bit [1:0] m_pend [2];
  int       m_ptr  [2];
  bit       m_vld  [2];
  bit [7:0] m_bus  [2];
  int       m_chan [2];
  bit [1:0] m_ovr  [2];

  task automatic model_clear();
    hist.delete();
    for (int m = 0; m < 2; m++) begin
      m_hold[m][0] = '0; m_hold[m][1] = '0;
      m_pend[m] = '0; m_ptr[m] = 0; m_vld[m] = 1'b0;
      m_bus[m] = '0; m_chan[m] = 0; m_ovr[m] = '0;
    end
  endtask

  // Advance the model by one edge using the inputs the DUT is about to sample,
  // then step the clock. An event seen at edge k+1 reflects the enable sampled
  // NS edges earlier versus the one before it.
  task automatic tick();
    int n, win;
    bit s, p, ld;
    bit [1:0] ev;
    n = hist.size();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < 2; c++) begin
        s = (n - NS >= 0)     ? hist[n-NS][c]   : 1'b0;
        p = (n - NS - 1 >= 0) ? hist[n-NS-1][c] : 1'b0;
        ev[c] = (m == 1) ? (s ^ p) : (s & ~p);
      end
      ld  = !m_vld[m] || rdy;
      win = -1;
      for (int i = 0; i < 2; i++)
        if (win < 0 && m_pend[m][(m_ptr[m] + i) % 2]) win = (m_ptr[m] + i) % 2;
      if (oclr) m_ovr[m] = '0;
      for (int c = 0; c < 2; c++)
        if (ev[c] && m_pend[m][c] && !(ld && win == c)) m_ovr[m][c] = 1'b1;
      if (ld) begin
        m_vld[m] = (win >= 0);
        if (win >= 0) begin
          m_bus[m]       = m_hold[m][win];
          m_chan[m]      = win;
          m_ptr[m]       = (win + 1) % 2;
          m_pend[m][win] = 1'b0;
        end
      end
      for (int c = 0; c < 2; c++)
        if (ev[c]) begin
          m_hold[m][c] = ubus[c*8 +: 8];
          m_pend[m][c] = 1'b1;
        end
    end
    hist.push_back(en);
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = '0; oclr = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- tests ---------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; en = '0; ubus = '0; rdy = 1'b1; oclr = 1'b0;
    model_clear();
    #2;
    for (int m = 0; m < 2; m++) begin
      checks++; if (vld_o[m] !== 1'b0) begin errors++; $display("FAIL reset_valid[%0d]: got %b want 0", m, vld_o[m]); end
      checks++; if (bus_o[m] !== 8'h00) begin errors++; $display("FAIL reset_bus[%0d]: got %h want 00", m, bus_o[m]); end
      checks++; if (chan_o[m] !== 1'b0) begin errors++; $display("FAIL reset_chan[%0d]: got %b want 0", m, chan_o[m]); end
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    ubus = 16'h00A5; en = 2'b01; rdy = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (vld_o[0] !== 1'b0) begin errors++; $display("FAIL single_early edge %0d: got %b want 0", k, vld_o[0]); end
    end
    tick();
    checks++;
    if (vld_o[0] !== 1'b1 || bus_o[0] !== 8'hA5 || chan_o[0] !== 1'b0) begin
      errors++; $display("FAIL single_word: got v=%b d=%h c=%b want v=1 d=a5 c=0", vld_o[0], bus_o[0], chan_o[0]);
    end
    tick();
    checks++; if (vld_o[0] !== 1'b0) begin errors++; $display("FAIL single_pulse: got %b want 0", vld_o[0]); end
  endtask

  task automatic test_both();
    apply_reset();
    rdy = 1'b1;
    for (int r = 0; r < 2; r++) begin
      ubus = 16'h2211; en = 2'b11;
      repeat (4) tick();
      checks++;
      if (vld_o[0] !== 1'b1 || chan_o[0] !== 1'b0 || bus_o[0] !== 8'h11) begin
        errors++; $display("FAIL both_first r%0d: got v=%b c=%b d=%h want v=1 c=0 d=11", r, vld_o[0], chan_o[0], bus_o[0]);
      end
      tick();
      checks++;
      if (vld_o[0] !== 1'b1 || chan_o[0] !== 1'b1 || bus_o[0] !== 8'h22) begin
        errors++; $display("FAIL both_second r%0d: got v=%b c=%b d=%h want v=1 c=1 d=22", r, vld_o[0], chan_o[0], bus_o[0]);
      end
      tick();
      checks++; if (vld_o[0] !== 1'b0) begin errors++; $display("FAIL both_idle r%0d: got %b want 0", r, vld_o[0]); end
      en = 2'b00;
      repeat (6) tick();
    end
  endtask

  task automatic test_backpressure();
    rdy = 1'b0; ubus = 16'h6B5A; en = 2'b11;
    repeat (4) tick();
    checks++;
    if (vld_o[0] !== 1'b1 || chan_o[0] !== 1'b0 || bus_o[0] !== 8'h5A) begin
      errors++; $display("FAIL bp_load: got v=%b c=%b d=%h want v=1 c=0 d=5a", vld_o[0], chan_o[0], bus_o[0]);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (vld_o[0] !== 1'b1 || chan_o[0] !== 1'b0 || bus_o[0] !== 8'h5A) begin
        errors++; $display("FAIL bp_hold cyc %0d: got v=%b c=%b d=%h want v=1 c=0 d=5a", k, vld_o[0], chan_o[0], bus_o[0]);
      end
    end
    rdy = 1'b1;
    tick();
    checks++;
    if (vld_o[0] !== 1'b1 || chan_o[0] !== 1'b1 || bus_o[0] !== 8'h6B) begin
      errors++; $display("FAIL bp_drain: got v=%b c=%b d=%h want v=1 c=1 d=6b", vld_o[0], chan_o[0], bus_o[0]);
    end
    tick();
    checks++; if (vld_o[0] !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", vld_o[0]); end
  endtask

  task automatic test_toggle();
    int nw;
    bit [7:0] w0, w1;
    bit c0, c1;
    apply_reset();
    rdy = 1'b1; nw = 0; w0 = '0; w1 = '0; c0 = 1'b0; c1 = 1'b0;
    ubus = 16'h3C00; en = 2'b10;
    for (int k = 0; k < 16; k++) begin
      if (k == 6) begin ubus = 16'hC300; en = 2'b00; end
      tick();
      if (vld_o[1] === 1'b1) begin
        if (nw == 0) begin w0 = bus_o[1]; c0 = chan_o[1]; end
        if (nw == 1) begin w1 = bus_o[1]; c1 = chan_o[1]; end
        nw++;
      end
    end
    checks++; if (nw != 2) begin errors++; $display("FAIL toggle_count: got %0d want 2", nw); end
    checks++; if (w0 !== 8'h3C || c0 !== 1'b1) begin errors++; $display("FAIL toggle_word0: got d=%h c=%b want d=3c c=1", w0, c0); end
    checks++; if (w1 !== 8'hC3 || c1 !== 1'b1) begin errors++; $display("FAIL toggle_word1: got d=%h c=%b want d=c3 c=1", w1, c1); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      en   = 2'($urandom);
      ubus = 16'($urandom);
      rdy  = ($urandom_range(0, 3) != 0);
      oclr = ($urandom_range(0, 15) == 0);
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (vld_o[m] !== m_vld[m]) begin
          errors++; $display("FAIL rand_valid[%0d] cyc %0d: got %b want %b", m, k, vld_o[m], m_vld[m]);
        end
        if (m_vld[m]) begin
          checks++;
          if (bus_o[m] !== m_bus[m] || chan_o[m] !== 1'(m_chan[m])) begin
            errors++; $display("FAIL rand_word[%0d] cyc %0d: got d=%h c=%b want d=%h c=%0d", m, k, bus_o[m], chan_o[m], m_bus[m], m_chan[m]);
          end
        end
`ifdef DATA_SYNC_OVERRUN_EN
        checks++;
        if (ovr_o[m] !== m_ovr[m]) begin
          errors++; $display("FAIL rand_overrun[%0d] cyc %0d: got %b want %b", m, k, ovr_o[m], m_ovr[m]);
        end
`endif
      end
    end
    oclr = 1'b0;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    rdy = 1'b0; ubus = 16'h2211; en = 2'b11;
    repeat (4) tick();
    en = 2'b00;
    repeat (2) tick();
    ubus = 16'h4433; en = 2'b11;
    repeat (3) tick();
    checks++; if (vld_o[0] !== 1'b1) begin errors++; $display("FAIL rmid_pre: got %b want 1", vld_o[0]); end
    rst = 1'b1;
    #1;
    checks++;
    if (vld_o[0] !== 1'b0 || vld_o[1] !== 1'b0) begin
      errors++; $display("FAIL rmid_async: got %b/%b want 0/0", vld_o[0], vld_o[1]);
    end
    en = 2'b00;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (vld_o[0] !== 1'b0 || vld_o[1] !== 1'b0) begin
        errors++; $display("FAIL rmid_after cyc %0d: got %b/%b want 0/0", k, vld_o[0], vld_o[1]);
      end
    end
  endtask

  task automatic test_enable_held();
    int cnt[2];
    rst = 1'b1; en = 2'b11; ubus = 16'h8877; rdy = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cnt[0] = 0; cnt[1] = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      for (int m = 0; m < 2; m++) if (vld_o[m] === 1'b1) cnt[m]++;
    end
    checks++; if (cnt[0] != 2) begin errors++; $display("FAIL held_level: got %0d words want 2", cnt[0]); end
    checks++; if (cnt[1] != 2) begin errors++; $display("FAIL held_toggle: got %0d words want 2", cnt[1]); end
  endtask

`ifdef DATA_SYNC_OVERRUN_EN
  task automatic test_overrun();
    apply_reset();
    rdy = 1'b0; ubus = 16'h0055; en = 2'b01;
    repeat (4) tick();
    en = 2'b00; repeat (2) tick();
    ubus = 16'h0066; en = 2'b01; repeat (3) tick();
    en = 2'b00; repeat (2) tick();
    ubus = 16'h0077; en = 2'b01; repeat (3) tick();
    checks++; if (ovr_o[0] !== 2'b01) begin errors++; $display("FAIL ovr_set: got %b want 01", ovr_o[0]); end
    rdy = 1'b1;
    tick();
    checks++;
    if (vld_o[0] !== 1'b1 || bus_o[0] !== 8'h77 || chan_o[0] !== 1'b0) begin
      errors++; $display("FAIL ovr_word: got v=%b d=%h c=%b want v=1 d=77 c=0", vld_o[0], bus_o[0], chan_o[0]);
    end
    oclr = 1'b1;
    tick();
    oclr = 1'b0;
    checks++; if (ovr_o[0] !== 2'b00) begin errors++; $display("FAIL ovr_clear: got %b want 00", ovr_o[0]); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_both();
    test_backpressure();
    test_toggle();
    test_random();
    test_reset_mid();
    test_enable_held();
`ifdef DATA_SYNC_OVERRUN_EN
    test_overrun();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
